nco_cnt_disp_gen: RTL

//  Parametrised NCO-timed N-digit counter with multiplexed 7-segment display driver.

---
 rtl/nco_cnt_disp_gen_if.sv | 28 ++
 rtl/nco_cnt_disp_gen.sv | 107 ++++++++++
 2 files changed

// File: rtl/nco_cnt_disp_gen_if.sv
// nco_cnt_disp_gen_if: control and display bundle between the board top and the NCO counter/display block
interface nco_cnt_disp_gen_if #(
  parameter int NUM_DIGIT = 6,
  parameter int NCO_W = 32
);
  logic [NCO_W-1:0] i_nco_num;
  logic i_run;
  logic i_down;
  logic i_hex;
  logic i_clear;
  logic i_load;
  logic [4*NUM_DIGIT-1:0] i_load_val;
  logic i_blank_lz;
  logic [NUM_DIGIT-1:0] i_dp_mask;
  logic o_tick;
  logic o_wrap;
  logic [NUM_DIGIT-1:0] o_seg_enb;
  logic o_seg_dp;
  logic [6:0] o_seg;
  modport master (
    output i_nco_num, i_run, i_down, i_hex, i_clear, i_load, i_load_val, i_blank_lz, i_dp_mask,
    input o_tick, o_wrap, o_seg_enb, o_seg_dp, o_seg
  );
  modport slave (
    input i_nco_num, i_run, i_down, i_hex, i_clear, i_load, i_load_val, i_blank_lz, i_dp_mask,
    output o_tick, o_wrap, o_seg_enb, o_seg_dp, o_seg
  );
endinterface

// File: rtl/nco_cnt_disp_gen.sv
// nco_cnt_disp_gen: NCO-timed N-digit decimal/hex up/down counter driving a scanned 7-segment display
module nco_cnt_disp_gen #(
  parameter int NUM_DIGIT = 6,
  parameter int NCO_W = 32,
  parameter int SCAN_DIV = 50000
) (
  input logic clk,
  input logic rst_n,
  nco_cnt_disp_gen_if.slave bus
);
  localparam int CW = 4 * NUM_DIGIT;
  localparam int IW = $clog2(NUM_DIGIT);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGIT - 1);
  localparam logic [SW-1:0] LAST_SCAN = SW'(SCAN_DIV - 1);
  logic [NCO_W-1:0] r_acc;
  logic [NCO_W:0] w_sum;
  logic r_tick, r_wrap, r_hex, r_seg_dp;
  logic [CW-1:0] r_cnt, w_step;
  logic w_cout, w_clr, w_blank;
  logic [3:0] w_max, w_dig;
  logic [IW-1:0] r_idx;
  logic [SW-1:0] r_scan;
  logic [NUM_DIGIT-1:0] r_seg_enb, w_nz;
  logic [6:0] r_seg;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b1111110;
      4'h1: seg7 = 7'b0110000;
      4'h2: seg7 = 7'b1101101;
      4'h3: seg7 = 7'b1111001;
      4'h4: seg7 = 7'b0110011;
      4'h5: seg7 = 7'b1011011;
      4'h6: seg7 = 7'b1011111;
      4'h7: seg7 = 7'b1110000;
      4'h8: seg7 = 7'b1111111;
      4'h9: seg7 = 7'b1111011;
      4'ha: seg7 = 7'b1110111;
      4'hb: seg7 = 7'b0011111;
      4'hc: seg7 = 7'b1001110;
      4'hd: seg7 = 7'b0111101;
      4'he: seg7 = 7'b1001111;
      default: seg7 = 7'b1000111;
    endcase
  endfunction
  assign w_sum = {1'b0, r_acc} + {1'b0, bus.i_nco_num};
  assign w_max = bus.i_hex ? 4'hf : 4'h9;
  // a radix change invalidates the stored digits, so it acts like a clear
  assign w_clr = bus.i_clear | (bus.i_hex ^ r_hex);
  always_comb begin
    logic c;
    logic [3:0] d;
    c = 1'b1;
    w_step = r_cnt;
    for (int k = 0; k < NUM_DIGIT; k++) begin
      d = r_cnt[4*k +: 4];
      if (c && !bus.i_down) begin
        w_step[4*k +: 4] = (d >= w_max) ? 4'h0 : d + 4'h1;
        c = d >= w_max;
      end else if (c) begin
        w_step[4*k +: 4] = (d == 4'h0 || d > w_max) ? w_max : d - 4'h1;
        c = d == 4'h0;
      end
    end
    w_cout = c;
  end
  always_comb begin
    logic a;
    a = 1'b0;
    for (int k = NUM_DIGIT - 1; k >= 0; k--) begin
      a = a | (|r_cnt[4*k +: 4]);
      w_nz[k] = a;
    end
  end
  assign w_dig = r_cnt[{r_idx, 2'b00} +: 4];
  assign w_blank = bus.i_blank_lz & (r_idx != '0) & ~w_nz[r_idx];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      r_hex <= 1'b0;
      r_cnt <= '0;
      r_scan <= '0;
      r_idx <= '0;
      r_seg_enb <= '1;
      r_seg <= '0;
      r_seg_dp <= 1'b0;
    end else begin
      r_acc <= w_sum[NCO_W-1:0];
      r_tick <= w_sum[NCO_W];
      r_hex <= bus.i_hex;
      r_wrap <= ~w_clr & ~bus.i_load & r_tick & bus.i_run & w_cout;
      r_cnt <= w_clr ? '0 : bus.i_load ? bus.i_load_val : (r_tick & bus.i_run) ? w_step : r_cnt;
      r_scan <= (r_scan == LAST_SCAN) ? '0 : r_scan + SW'(1);
      r_idx <= (r_scan != LAST_SCAN) ? r_idx : (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
      r_seg_enb <= ~(NUM_DIGIT'(1) << r_idx);
      r_seg <= w_blank ? '0 : seg7(w_dig);
      r_seg_dp <= bus.i_dp_mask[r_idx];
    end
  end
  assign bus.o_tick = r_tick;
  assign bus.o_wrap = r_wrap;
  assign bus.o_seg_enb = r_seg_enb;
  assign bus.o_seg = r_seg;
  assign bus.o_seg_dp = r_seg_dp;
endmodule
